d_mem_dma_initiator: RTL and testbench

//  Memory-request initiator (DMA copy engine) that drives the request side of the data-memory

---
 rtl/d_mem_dma_initiator_if.sv | 22 ++
 rtl/d_mem_dma_initiator.sv | 135 +++++++++++++
 tb/tb_d_mem_dma_initiator.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/d_mem_dma_initiator_if.sv
// Request/response bundle between the DMA initiator and the data-memory responder.
interface d_mem_dma_initiator_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
);
  logic                    mem_read;
  logic                    mem_write;
  logic [ADDRESS_BITS-1:0] mem_address;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_valid;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_valid
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_valid
  );
endinterface

// File: rtl/d_mem_dma_initiator.sv
// DMA copy engine: reads a word at src, writes it to dst, repeats for length words.
// 2 cycles/word with same-cycle mem_valid; requests are held until mem_valid or timeout.
module d_mem_dma_initiator #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int LEN_BITS       = 16,
  parameter int ADDR_STEP      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] src_addr,
  input  logic [ADDRESS_BITS-1:0] dst_addr,
  input  logic [LEN_BITS-1:0]     length,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    aborted,
  output logic [LEN_BITS-1:0]     words_done,
  d_mem_dma_initiator_if.master   mem
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, FINISH} state_t;

  state_t                  state, state_nxt;
  logic [ADDRESS_BITS-1:0] cur_src, cur_dst;
  logic [LEN_BITS-1:0]     remaining, words_cnt;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [TW-1:0]           tcount;
  logic                    abort_q, error_q, aborted_q;
  logic                    tmo, stop_req;

  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);
  assign error      = error_q;
  assign aborted    = aborted_q;
  assign words_done = words_cnt;

  always_comb begin
    state_nxt       = state;
    mem.mem_read    = 1'b0;
    mem.mem_write   = 1'b0;
    mem.mem_address = '0;
    mem.mem_wdata   = '0;
    // mem_valid takes priority over an expiring timeout
    tmo      = !mem.mem_valid && (tcount == TW'(TIMEOUT_CYCLES - 1));
    stop_req = abort_q || abort;
    case (state)
      IDLE: begin
        if (start) state_nxt = (length == '0) ? FINISH : RD_REQ;
      end
      RD_REQ: begin
        mem.mem_read    = 1'b1;
        mem.mem_address = cur_src;
        if (mem.mem_valid) state_nxt = WR_REQ;
        else if (tmo)      state_nxt = FINISH;
      end
      WR_REQ: begin
        mem.mem_write   = 1'b1;
        mem.mem_address = cur_dst;
        mem.mem_wdata   = data_q;
        if (mem.mem_valid)
          state_nxt = (remaining == LEN_BITS'(1) || stop_req) ? FINISH : RD_REQ;
        else if (tmo)
          state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      words_cnt <= '0;
      data_q    <= '0;
      tcount    <= '0;
      abort_q   <= 1'b0;
      error_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (state_nxt != state)
        tcount <= '0;
      else if (!mem.mem_valid && (state == RD_REQ || state == WR_REQ))
        tcount <= tcount + TW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            cur_src   <= src_addr;
            cur_dst   <= dst_addr;
            remaining <= length;
            words_cnt <= '0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            abort_q   <= 1'b0;
          end
        end
        RD_REQ: begin
          if (abort) abort_q <= 1'b1;
          if (mem.mem_valid) data_q  <= mem.mem_rdata;
          else if (tmo)      error_q <= 1'b1;
        end
        WR_REQ: begin
          if (abort) abort_q <= 1'b1;
          if (mem.mem_valid) begin
            words_cnt <= words_cnt + LEN_BITS'(1);
            cur_src   <= cur_src + ADDRESS_BITS'(ADDR_STEP);
            cur_dst   <= cur_dst + ADDRESS_BITS'(ADDR_STEP);
            remaining <= remaining - LEN_BITS'(1);
            if (stop_req) aborted_q <= 1'b1;
          end else if (tmo) begin
            error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d_mem_dma_initiator.sv
// Scoreboard bench: stimulus pushes expected memory completions and done status; a negedge monitor pops and compares.
module tb_d_mem_dma_initiator;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] length;
  logic        busy, done, error, aborted;
  logic [15:0] words_done;

  int vectors = 0;
  int fails   = 0;

  d_mem_dma_initiator_if #(.DATA_WIDTH(32), .ADDRESS_BITS(32)) mem_if ();

  d_mem_dma_initiator #(
    .DATA_WIDTH(32), .ADDRESS_BITS(32), .LEN_BITS(16),
    .ADDR_STEP(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .abort(abort), .busy(busy), .done(done), .error(error),
    .aborted(aborted), .words_done(words_done), .mem(mem_if)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Responder: completes each request after stall_n wait cycles unless disabled
  int         stall_n = 0;
  logic       resp_en = 1'b1;
  logic [7:0] wait_cnt = '0;
  always @(posedge clock) begin
    if (!(mem_if.mem_read || mem_if.mem_write) || mem_if.mem_valid) wait_cnt <= '0;
    else wait_cnt <= wait_cnt + 8'd1;
  end
  assign mem_if.mem_valid = resp_en && (mem_if.mem_read || mem_if.mem_write)
                            && (int'(wait_cnt) >= stall_n);
  assign mem_if.mem_rdata = rd_model(mem_if.mem_address);

  typedef struct {
    int          kind;   // 0 read, 1 write, 2 done
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] wd;
    logic        err;
    logic        ab;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_rd(input logic [31:0] a);
    exp_t e; e = '{0, a, 32'h0, 16'h0, 1'b0, 1'b0}; sb.push_back(e);
  endtask
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_t e; e = '{1, a, d, 16'h0, 1'b0, 1'b0}; sb.push_back(e);
  endtask
  task automatic push_done(input logic [15:0] wd, input logic er, input logic ab);
    exp_t e; e = '{2, 32'h0, 32'h0, wd, er, ab}; sb.push_back(e);
  endtask

  // Monitor
  logic        prev_pending = 1'b0;
  logic        prev_wr = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge clock) begin
    if (!reset) begin
      prev_pending = 1'b0;
    end else begin
      exp_t e;
      if (mem_if.mem_read && mem_if.mem_write) check("rw_exclusive", 1, 0);
      if (prev_pending && (mem_if.mem_read || mem_if.mem_write)) begin
        check("hold_kind", {63'b0, mem_if.mem_write}, {63'b0, prev_wr});
        check("hold_addr", mem_if.mem_address, prev_addr);
        if (mem_if.mem_write) check("hold_wdata", mem_if.mem_wdata, prev_wdata);
      end
      if ((mem_if.mem_read || mem_if.mem_write) && mem_if.mem_valid) begin
        if (sb.size() == 0) begin
          vectors++; fails++;
          $display("FAIL unexpected_req: addr %0h with empty scoreboard", mem_if.mem_address);
        end else begin
          e = sb.pop_front();
          check("req_kind", mem_if.mem_write ? 1 : 0, e.kind);
          check("req_addr", mem_if.mem_address, e.addr);
          if (mem_if.mem_write) check("req_wdata", mem_if.mem_wdata, e.data);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          vectors++; fails++;
          $display("FAIL unexpected_done: done pulse with empty scoreboard");
        end else begin
          e = sb.pop_front();
          check("done_kind", 2, e.kind);
          check("done_words", words_done, e.wd);
          check("done_error", error, e.err);
          check("done_aborted", aborted, e.ab);
          check("done_busy", busy, 1);
        end
      end
      prev_pending = (mem_if.mem_read || mem_if.mem_write) && !mem_if.mem_valid;
      prev_wr      = mem_if.mem_write;
      prev_addr    = mem_if.mem_address;
      prev_wdata   = mem_if.mem_wdata;
    end
  end

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int exp_lat, input int exp_req, input int abort_at,
                          input int restart_at, input string name);
    int cyc, req_cycles;
    @(posedge clock); #1;
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1; req_cycles = 0;
    while (!done && cyc < 300) begin
      if (mem_if.mem_read || mem_if.mem_write) req_cycles++;
      abort = (cyc == abort_at);
      if (cyc == restart_at) begin
        start = 1'b1; src_addr = 32'h900; dst_addr = 32'h990; length = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    abort = 1'b0; start = 1'b0;
    check({name, "_latency"}, cyc, exp_lat);
    if (exp_req >= 0) check({name, "_req_cycles"}, req_cycles, exp_req);
    repeat (2) @(posedge clock);
    #1;
    check({name, "_busy_after"}, busy, 0);
    check({name, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_aborted", aborted, 0);
    check("rst_words", words_done, 0);
    check("rst_read", mem_if.mem_read, 0);
    check("rst_write", mem_if.mem_write, 0);
    check("rst_addr", mem_if.mem_address, 0);
    reset = 1'b1;

    // 4-word copy, zero-wait responder
    for (int i = 0; i < 4; i++) begin
      push_rd(32'h100 + 32'(4 * i));
      push_wr(32'h200 + 32'(4 * i), rd_model(32'h100 + 32'(4 * i)));
    end
    push_done(16'd4, 1'b0, 1'b0);
    run_xfer(32'h100, 32'h200, 16'd4, 9, 8, -1, -1, "copy4");

    // zero length: no requests at all
    push_done(16'd0, 1'b0, 1'b0);
    run_xfer(32'h100, 32'h200, 16'd0, 1, 0, -1, -1, "len0");

    // responder stalls 3 cycles per request
    stall_n = 3;
    for (int i = 0; i < 3; i++) begin
      push_rd(32'h1000 + 32'(4 * i));
      push_wr(32'h2000 + 32'(4 * i), rd_model(32'h1000 + 32'(4 * i)));
    end
    push_done(16'd3, 1'b0, 1'b0);
    run_xfer(32'h1000, 32'h2000, 16'd3, 25, 24, -1, -1, "stall3");
    stall_n = 0;

    // responder silent: read held 8 cycles then dropped with error
    resp_en = 1'b0;
    push_done(16'd0, 1'b1, 1'b0);
    run_xfer(32'hA00, 32'hB00, 16'd2, 9, 8, -1, -1, "timeout");
    check("timeout_error_sticky", error, 1);
    resp_en = 1'b1;

    // abort during second word's read: that word still completes
    push_rd(32'h300); push_wr(32'h400, rd_model(32'h300));
    push_rd(32'h304); push_wr(32'h404, rd_model(32'h304));
    push_done(16'd2, 1'b0, 1'b1);
    run_xfer(32'h300, 32'h400, 16'd5, 5, 4, 3, -1, "abort");
    check("abort_sticky", aborted, 1);

    // source wraps to 0; a start while busy is ignored
    push_rd(32'hFFFF_FFFC); push_wr(32'h500, rd_model(32'hFFFF_FFFC));
    push_rd(32'h0000_0000); push_wr(32'h504, rd_model(32'h0000_0000));
    push_done(16'd2, 1'b0, 1'b0);
    run_xfer(32'hFFFF_FFFC, 32'h500, 16'd2, 5, 4, -1, 2, "wrap");
    check("wrap_words_done", words_done, 2);

    // reset mid-transfer: first word completes, then everything drops with no done
    push_rd(32'h700); push_wr(32'h800, rd_model(32'h700));
    @(posedge clock); #1;
    src_addr = 32'h700; dst_addr = 32'h800; length = 16'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_read", mem_if.mem_read, 0);
    check("midrst_write", mem_if.mem_write, 0);
    check("midrst_done", done, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("midrst_sb_drained", sb.size(), 0);
    check("midrst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
